// File: rtl/seq_pkg.sv
// Shared types and sizing for the multi-cycle sequencer and its wait timer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam int DEF_MAX_WAIT = 16;
    localparam int WAIT_W       = $clog2(DEF_MAX_WAIT + 1);

    function automatic int wait_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Not-ready cycle counter shared by FETCH and MEM; expired_o flags the last tolerated wait cycle.
module wait_timer
    import seq_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int CW       = WAIT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(MAX_WAIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps IF/ID/EX/MEM/WB one stage at a time, supervises memory
// handshakes with a timeout, gates PC/register writes and counts retired instructions.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | imem request outstanding, wait_cnt counts not-ready cycles
// DECODE | id_en for one cycle
// EXEC   | ex_en, decode flags latched; may retire here
// MEM    | dmem request outstanding; store retires here
// WB     | register write strobe, always retires
// HALT   | parked after a retire with halt_req; start resumes
// ERR    | memory timeout, sticky until reset
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             reg_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic             ld_q, st_q, rw_q, br_q;
    logic             ld_d, st_d, rw_d, br_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    logic             tmr_inc;
    logic             tmr_expired;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CW       (wait_width(MAX_WAIT))
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst),
        .clr_i     (~tmr_inc),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        st_d     = st_q;
        rw_d     = rw_q;
        br_d     = br_q;
        count_d  = count_q;
        retire   = 1'b0;
        tmr_inc  = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        mem_en   = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        err      = 1'b0;
        busy     = !(state_q inside {S_IDLE, S_HALT, S_ERR});

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    state_d = S_ERR;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            S_DECODE: begin
                id_en   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ex_en = 1'b1;
                ld_d  = dec_mem_read;
                // read+write together is resolved as a load
                st_d  = dec_mem_write & ~dec_mem_read;
                rw_d  = dec_reg_write;
                br_d  = branch_taken;
                if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    retire = 1'b1;
                    pc_sel = branch_taken;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_q;
                if (dmem_ready) begin
                    mem_en = ld_q;
                    if (ld_q) begin
                        state_d = S_WB;
                    end else begin
                        retire = 1'b1;
                        pc_sel = br_q;
                    end
                end else if (tmr_expired) begin
                    state_d = S_ERR;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            S_WB: begin
                reg_we = rw_q;
                retire = 1'b1;
                pc_sel = br_q;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            pc_we   = 1'b1;
            count_d = count_q + 1'b1;
            state_d = halt_req ? S_HALT : S_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            rw_q    <= rw_d;
            br_q    <= br_d;
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: stimulus queues hand-computed per-cycle expectations, a monitor pops and compares.
module tb_multicycle_sequencer;

    localparam int CNT_W = 32;
    localparam int MW    = 4;

    // expected output word: imem_req dmem_req dmem_we if_en id_en ex_en mem_en reg_we pc_we pc_sel busy err
    localparam logic [11:0] O_IDLE = 12'b0000_0000_0000;
    localparam logic [11:0] O_FW   = 12'b1000_0000_0010;
    localparam logic [11:0] O_FR   = 12'b1001_0000_0010;
    localparam logic [11:0] O_DEC  = 12'b0000_1000_0010;
    localparam logic [11:0] O_EX   = 12'b0000_0100_0010;
    localparam logic [11:0] O_EXR  = 12'b0000_0100_1010;
    localparam logic [11:0] O_EXB  = 12'b0000_0100_1110;
    localparam logic [11:0] O_MLW  = 12'b0100_0000_0010;
    localparam logic [11:0] O_MSW  = 12'b0110_0000_0010;
    localparam logic [11:0] O_MLR  = 12'b0100_0010_0010;
    localparam logic [11:0] O_MSR  = 12'b0110_0000_1010;
    localparam logic [11:0] O_WB   = 12'b0000_0001_1010;
    localparam logic [11:0] O_WBN  = 12'b0000_0000_1010;
    localparam logic [11:0] O_ERR  = 12'b0000_0000_0001;

    logic clk = 1'b0;
    logic rst, start, halt_req, imem_ready, dmem_ready;
    logic dec_mem_read, dec_mem_write, dec_reg_write, branch_taken;
    logic imem_req, dmem_req, dmem_we, if_en, id_en, ex_en, mem_en;
    logic reg_we, pc_we, pc_sel, busy, err;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt_req      (halt_req),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .branch_taken  (branch_taken),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .if_en         (if_en),
        .id_en         (id_en),
        .ex_en         (ex_en),
        .mem_en        (mem_en),
        .reg_we        (reg_we),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .busy          (busy),
        .err           (err),
        .instr_count   (instr_count)
    );

    typedef struct packed {
        logic [11:0]      outs;
        logic [CNT_W-1:0] cnt;
        logic [15:0]      step;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    wire [11:0] obs = {imem_req, dmem_req, dmem_we, if_en, id_en, ex_en,
                       mem_en, reg_we, pc_we, pc_sel, busy, err};

    // input word: rst start halt_req imem_ready dmem_ready mem_read mem_write reg_write branch
    task automatic cyc(input logic [8:0] iv, input logic [11:0] eo, input int ecnt);
        @(posedge clk);
        #1;
        {rst, start, halt_req, imem_ready, dmem_ready,
         dec_mem_read, dec_mem_write, dec_reg_write, branch_taken} = iv;
        exp_q.push_back('{outs: eo, cnt: CNT_W'(ecnt), step: 16'(step_no)});
        step_no++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs !== e.outs) begin
                    errors++;
                    $display("FAIL outputs step %0d got %b want %b", e.step, obs, e.outs);
                end
                checks++;
                if (instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL instr_count step %0d got %0d want %0d", e.step, instr_count, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        {rst, start, halt_req, imem_ready, dmem_ready,
         dec_mem_read, dec_mem_write, dec_reg_write, branch_taken} = '0;

        // reset, then ALU op with register write
        cyc(9'b0_0_0_0_0_0_0_0_0, O_IDLE, 0);
        cyc(9'b0_0_0_0_0_0_0_0_0, O_IDLE, 0);
        cyc(9'b1_1_0_1_1_0_0_1_0, O_IDLE, 0);
        cyc(9'b1_0_0_1_1_0_0_1_0, O_FR,   0);
        cyc(9'b1_0_0_1_1_0_0_1_0, O_DEC,  0);
        cyc(9'b1_0_0_1_1_0_0_1_0, O_EX,   0);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_WB,   0);

        // load, dmem ready arrives in the fourth MEM cycle
        cyc(9'b1_0_0_1_0_0_0_0_0, O_FR,   1);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_DEC,  1);
        cyc(9'b1_0_0_1_0_1_0_1_0, O_EX,   1);
        for (int i = 0; i < 3; i++) cyc(9'b1_0_0_1_0_0_0_0_0, O_MLW, 1);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_MLR,  1);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_WB,   1);

        // taken branch retires in EXEC
        cyc(9'b1_0_0_1_1_0_0_0_0, O_FR,   2);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_DEC,  2);
        cyc(9'b1_0_0_1_1_0_0_0_1, O_EXB,  2);

        // store with one wait, halt at retire, then resume
        cyc(9'b1_0_0_1_1_0_0_0_0, O_FR,   3);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_DEC,  3);
        cyc(9'b1_0_0_1_1_0_1_0_0, O_EX,   3);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_MSW,  3);
        cyc(9'b1_0_1_1_1_0_0_0_0, O_MSR,  3);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_IDLE, 4);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_IDLE, 4);
        cyc(9'b1_1_0_1_1_0_0_0_0, O_IDLE, 4);

        // read+write together behaves as a load; no reg_we without reg_write
        cyc(9'b1_0_0_1_1_0_0_0_0, O_FR,   4);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_DEC,  4);
        cyc(9'b1_0_0_1_1_1_1_0_0, O_EX,   4);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_MLR,  4);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_WBN,  4);

        // reset during MEM of a store aborts it
        cyc(9'b1_0_0_1_1_0_0_0_0, O_FR,   5);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_DEC,  5);
        cyc(9'b1_0_0_1_0_0_1_0_0, O_EX,   5);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_MSW,  5);
        cyc(9'b0_0_0_1_1_0_0_0_0, O_IDLE, 0);
        cyc(9'b0_0_0_1_1_0_0_0_0, O_IDLE, 0);
        cyc(9'b1_0_0_1_1_0_0_0_0, O_IDLE, 0);

        // fetch timeout into sticky ERR, cleared only by reset
        cyc(9'b1_1_0_0_0_0_0_0_0, O_IDLE, 0);
        for (int i = 0; i < MW; i++) cyc(9'b1_0_0_0_0_0_0_0_0, O_FW, 0);
        for (int i = 0; i < 3; i++) cyc(9'b1_1_0_1_1_0_0_1_0, O_ERR, 0);
        cyc(9'b0_0_0_0_0_0_0_0_0, O_IDLE, 0);

        // ready in the last tolerated wait cycle completes; NOP retires with halt
        cyc(9'b1_1_0_0_0_0_0_0_0, O_IDLE, 0);
        for (int i = 0; i < MW - 1; i++) cyc(9'b1_0_0_0_0_0_0_0_0, O_FW, 0);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_FR,   0);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_DEC,  0);
        cyc(9'b1_0_1_1_0_0_0_0_0, O_EXR,  0);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_IDLE, 1);
        cyc(9'b1_0_0_1_0_0_0_0_0, O_IDLE, 1);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that replaces the free-running, all-stages-every-cycle operation of the single-cycle core.
- Sequences IF, ID, EX, MEM and WB one stage at a time through per-stage enables.
- Runs a request/ready handshake with instruction and data memory, and supervises both handshakes with a timeout.
- Gates PC and register-file writes, counts retired instructions, and supports halt/restart.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MAX_WAIT, 16: maximum consecutive not-ready cycles tolerated in FETCH or MEM before the FSM enters ERR. Must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  level; leaves IDLE or HALT.
- halt_req  in  1  sampled at retire; if 1, go to HALT instead of FETCH.
- imem_ready  in  1  instruction memory has a valid word.
- dmem_ready  in  1  data memory has completed the access.
- dec_mem_read  in  1  decoded load, sampled in EXEC.
- dec_mem_write  in  1  decoded store, sampled in EXEC.
- dec_reg_write  in  1  decoded register write, sampled in EXEC.
- branch_taken  in  1  valid taken branch from MEM-stage logic, sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a write.
- if_en  out  1  latch the fetched instruction.
- id_en  out  1  latch decode/register-read results.
- ex_en  out  1  latch ALU/branch results.
- mem_en  out  1  latch load data.
- reg_we  out  1  register-file write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  PC source: 0 = PC+4, 1 = branch target.
- busy  out  1  1 in any state other than IDLE, HALT or ERR.
- err  out  1  sticky memory-timeout flag.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR (3-bit encoding). All outputs decode combinationally from the state register, the latched decode flags and the ready inputs.
- Reset (rst=0, asynchronous):
  - state=IDLE; all strobes and requests 0; pc_sel=0; err=0; instr_count=0; latched flags=0; wait_cnt=0.
  - Reset mid-instruction aborts it: no pc_we and no reg_we are issued.
- IDLE: if start=1 → FETCH.
- FETCH:
  - imem_req=1.
  - If imem_ready=1: if_en=1 and → DECODE.
  - Otherwise wait_cnt++. If wait_cnt==MAX_WAIT-1 and still not ready → ERR.
- DECODE: id_en=1 for one cycle → EXEC.
- EXEC:
  - ex_en=1. Latch ld=dec_mem_read, st=dec_mem_write, rw=dec_reg_write, br=branch_taken.
  - Next state: (mem_read|mem_write) → MEM; else reg_write → WB; else retire here.
- MEM:
  - dmem_req=1, dmem_we=st.
  - If dmem_ready=1: mem_en=ld; then → WB if ld, else retire here.
  - Timeout rule is identical to FETCH.
- WB: reg_we=1 for one cycle, then retire.
- Retire, in the instruction's final cycle:
  - pc_we=1; pc_sel=br (the combinational flag is used when retiring in EXEC).
  - instr_count += 1, wrapping modulo 2^CNT_W.
  - Next: halt_req ? HALT : FETCH.
- HALT: no strobes; start=1 → FETCH.
- ERR: err=1 and no strobes; stays in ERR until reset.
- wait_cnt clears on entry to FETCH and to MEM.
- Ready wins over timeout: ready asserted in the MAX_WAIT-th wait cycle still completes the stage normally.
- Illegal combination: dec_mem_read and dec_mem_write both 1 is treated as a load (dmem_we=0).
- Cycle counts with zero memory wait:
  - ALU with write: 4 cycles (F, D, E, W).
  - Store: 4 cycles (F, D, E, M).
  - Load: 5 cycles (F, D, E, M, W).
  - Branch/NOP: 3 cycles (F, D, E).
- Each memory wait cycle adds one cycle.
- At most one pc_we per instruction; reg_we is never asserted without rw=1.

Decomposition:
- Package seq_pkg holds:
  - state enum/localparams;
  - the default MAX_WAIT;
  - localparam WAIT_W = $clog2(MAX_WAIT+1).
- One sub-module, wait_timer: clear/increment counter producing an expired flag, instantiated once and shared by FETCH and MEM.

Test Plan:
1. Reset with rst=0, then release it with start=1 and imem_ready=dmem_ready=1; run an ALU instruction (reg_write=1). Required: imem_req at cycle 1, if_en/id_en/ex_en/reg_we in consecutive cycles, pc_we with reg_we and pc_sel=0, instr_count=1.
2. Load with dmem_ready delayed 3 cycles. Required: dmem_req held for 4 cycles, mem_en pulses once when ready, reg_we the next cycle, 8 cycles total, instr_count increments by 1.
3. Taken branch (branch_taken=1, no reg_write, no memory). Required: pc_we=1 and pc_sel=1 in EXEC, no reg_we, next cycle FETCH.
4. MAX_WAIT=4 with imem_ready held at 0. Required: ERR after 4 FETCH cycles, err=1 sticky, no strobes afterwards; rst=0 clears err. A second run with ready arriving in wait cycle 4 must complete normally.
5. halt_req=1 at a store's retire. Required: dmem_we=1 during MEM, then HALT with busy=0; start=1 resumes FETCH and instr_count continues.
6. Assert rst=0 during MEM of a store. Required: immediate IDLE, all outputs 0, pc_we never asserted, instr_count=0.
